writeback_queue: RTL and testbench

Write-back buffer for the MIPS pipeline. It is the producer side of the register-file write port. It accepts register write requests from two result sources, the single-cycle ALU path and the memory/load path, through valid/ready handshakes. Requests are queued in a small FIFO and drained at one write per cycle onto the register file's `regWrite`/`writeReg`/`writeData` port. A combinational forwarding lookup exposes pending, not-yet-committed values to the decode stage.

---
 rtl/writeback_queue.sv | 153 +++++++++++++++
 tb/tb_writeback_queue.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// writeback_queue: write-back buffer feeding the register-file write port.
// Accepts writes from the ALU path (fixed priority) and the memory/load path,
// queues them in a DEPTH-entry FIFO and drains one write per cycle onto
// regWrite/writeReg/writeData. A combinational lookup forwards the youngest
// pending value for fwd_reg. Requests to register 0 are acknowledged and dropped.
// Ports: clk, rst (async, active-low); alu_valid/alu_reg/alu_data/alu_ready;
//        mem_valid/mem_reg/mem_data/mem_ready; regWrite/writeReg/writeData;
//        fwd_reg/fwd_hit/fwd_data; count/full/empty.
// Build option: WBQ_BYPASS_EN loads a request straight into the output
//               registers when the FIFO is empty.
module writeback_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid,
  input  logic [AW-1:0]                alu_reg,
  input  logic [DW-1:0]                alu_data,
  output logic                         alu_ready,
  input  logic                         mem_valid,
  input  logic [AW-1:0]                mem_reg,
  input  logic [DW-1:0]                mem_data,
  output logic                         mem_ready,
  output logic                         regWrite,
  output logic [AW-1:0]                writeReg,
  output logic [DW-1:0]                writeData,
  input  logic [AW-1:0]                fwd_reg,
  output logic                         fwd_hit,
  output logic [DW-1:0]                fwd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0] qreg_q [DEPTH];
  logic [AW-1:0] qreg_d [DEPTH];
  logic [DW-1:0] qdat_q [DEPTH];
  logic [DW-1:0] qdat_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          reg_write_q, reg_write_d;
  logic [AW-1:0] write_reg_q, write_reg_d;
  logic [DW-1:0] write_data_q, write_data_d;

  logic          in_fire;
  logic [AW-1:0] in_reg;
  logic [DW-1:0] in_data;
  logic          push;
  logic          pop;
  logic          bypass;
  logic          enq;
  logic [PW-1:0] idx;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign alu_ready = !full;
  assign mem_ready = !full && !alu_valid;
  assign regWrite  = reg_write_q;
  assign writeReg  = write_reg_q;
  assign writeData = write_data_q;

  always_comb begin
    in_fire = (alu_valid && alu_ready) || (mem_valid && mem_ready);
    in_reg  = alu_valid ? alu_reg  : mem_reg;
    in_data = alu_valid ? alu_data : mem_data;
    push    = in_fire && (in_reg != '0);
    pop     = !empty;
`ifdef WBQ_BYPASS_EN
    bypass  = push && empty;
`else
    bypass  = 1'b0;
`endif
    enq     = push && !bypass;

    qreg_d       = qreg_q;
    qdat_d       = qdat_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    reg_write_d  = pop || bypass;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;

    if (pop) begin
      write_reg_d  = qreg_q[rd_ptr_q];
      write_data_d = qdat_q[rd_ptr_q];
      rd_ptr_d     = rd_ptr_q + PW'(1);
    end
    // bypass only occurs with an empty FIFO, so it never competes with pop
    if (bypass) begin
      write_reg_d  = in_reg;
      write_data_d = in_data;
    end
    if (enq) begin
      qreg_d[wr_ptr_q] = in_reg;
      qdat_d[wr_ptr_q] = in_data;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(enq) - CW'(pop);
  end

  // Output register is the oldest candidate; later queue matches overwrite it,
  // so the last match in oldest-to-youngest order is the youngest write.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    if (reg_write_q && (write_reg_q == fwd_reg)) begin
      fwd_hit  = 1'b1;
      fwd_data = write_data_q;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (qreg_q[idx] == fwd_reg)) begin
        fwd_hit  = 1'b1;
        fwd_data = qdat_q[idx];
      end
    end
    if (fwd_reg == '0) begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qreg_q       <= '{default: '0};
      qdat_q       <= '{default: '0};
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      qreg_q       <= qreg_d;
      qdat_q       <= qdat_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed scenarios plus randomized traffic checked
// cycle by cycle against a queue-based model of the pending writes, and an
// end-to-end check that issued writes match accepted writes in order.
module tb_writeback_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
`ifdef WBQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alu_valid = 1'b0;
  logic [AW-1:0] alu_reg = '0;
  logic [DW-1:0] alu_data = '0;
  logic          alu_ready;
  logic          mem_valid = 1'b0;
  logic [AW-1:0] mem_reg = '0;
  logic [DW-1:0] mem_data = '0;
  logic          mem_ready;
  logic          regWrite;
  logic [AW-1:0] writeReg;
  logic [DW-1:0] writeData;
  logic [AW-1:0] fwd_reg = '0;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic [2:0]    count;
  logic          full;
  logic          empty;

  writeback_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .fwd_reg(fwd_reg), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           mq[$];
  wr_t           accepted[$];
  wr_t           issued[$];
  bit            m_ow = 1'b0;
  logic [AW-1:0] m_wr = '0;
  logic [DW-1:0] m_wd = '0;
  logic [DW-1:0] rf [32];
  bit            last_a_acc;
  bit            last_m_acc;
  int            total = 0;
  int            bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int            n;
    bit            exp_hit;
    logic [DW-1:0] exp_fd;
    n = mq.size();
    check_eq("alu_ready", alu_ready, n != DEPTH);
    check_eq("mem_ready", mem_ready, (n != DEPTH) && !alu_valid);
    check_eq("count", count, n);
    check_eq("full", full, n == DEPTH);
    check_eq("empty", empty, n == 0);
    check_eq("regWrite", regWrite, m_ow);
    check_eq("writeReg", writeReg, m_wr);
    check_eq("writeData", writeData, m_wd);
    exp_hit = 1'b0;
    exp_fd  = '0;
    if (fwd_reg != '0) begin
      for (int i = n - 1; i >= 0; i--) begin
        if (!exp_hit && mq[i].r == fwd_reg) begin
          exp_hit = 1'b1;
          exp_fd  = mq[i].d;
        end
      end
      if (!exp_hit && m_ow && m_wr == fwd_reg) begin
        exp_hit = 1'b1;
        exp_fd  = m_wd;
      end
    end
    check_eq("fwd_hit", fwd_hit, exp_hit);
    check_eq("fwd_data", fwd_data, exp_fd);
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input bit av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                      input bit mv, input logic [AW-1:0] mr, input logic [DW-1:0] md,
                      input logic [AW-1:0] fr);
    bit  full_m, was_empty, acc;
    wr_t req;
    alu_valid = av; alu_reg = ar; alu_data = ad;
    mem_valid = mv; mem_reg = mr; mem_data = md;
    fwd_reg   = fr;
    @(negedge clk);
    check_outputs();
    if (regWrite === 1'b1) begin
      issued.push_back('{r: writeReg, d: writeData});
      rf[writeReg] = writeData;
    end
    full_m     = (mq.size() == DEPTH);
    last_a_acc = av && !full_m;
    last_m_acc = mv && !full_m && !av;
    acc        = last_a_acc || last_m_acc;
    req.r      = last_a_acc ? ar : mr;
    req.d      = last_a_acc ? ad : md;
    @(posedge clk);
    was_empty = (mq.size() == 0);
    if (!was_empty) begin
      req_pop: begin
        wr_t h;
        h    = mq.pop_front();
        m_wr = h.r;
        m_wd = h.d;
        m_ow = 1'b1;
      end
    end else begin
      m_ow = 1'b0;
    end
    if (acc && req.r != '0) begin
      accepted.push_back(req);
      if (BYP && was_empty) begin
        m_ow = 1'b1;
        m_wr = req.r;
        m_wd = req.d;
      end else begin
        mq.push_back(req);
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, AW'($urandom_range(0, 7)));
  endtask

  task automatic check_order();
    check_eq("issue_count", issued.size(), accepted.size());
    for (int i = 0; i < issued.size() && i < accepted.size(); i++)
      check_eq("issue_order", issued[i], accepted[i]);
    issued.delete();
    accepted.delete();
  endtask

  initial begin
    bit            mpend;
    logic          mv;
    logic [AW-1:0] mr;
    logic [DW-1:0] md;
    for (int i = 0; i < 32; i++) rf[i] = '0;

    #1 rst = 1'b0;
    #10;
    check_eq("rst_count", count, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_regWrite", regWrite, 0);
    check_eq("rst_writeReg", writeReg, 0);
    check_eq("rst_writeData", writeData, 0);
    check_eq("rst_fwd_hit", fwd_hit, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // single ALU write
    step(1'b1, 5'd5, 32'h0000_1234, 1'b0, '0, '0, 5'd5);
    idle(3);
    check_eq("rf_r5", rf[5], 32'h0000_1234);

    // arbitration: ALU first, stalled memory request held
    step(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, 5'd3);
    check_eq("arb_mem_stalled", last_m_acc, 0);
    step(1'b0, '0, '0, 1'b1, 5'd4, 32'hB, 5'd4);
    check_eq("arb_mem_taken", last_m_acc, 1);
    idle(3);

    // register 0 then two writes to r7
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0, '0, 5'd0);
    step(1'b1, 5'd7, 32'd1, 1'b0, '0, '0, 5'd7);
    step(1'b1, 5'd7, 32'd2, 1'b0, '0, '0, 5'd7);
    fwd_reg = 5'd7;
    #1;
    check_eq("fwd_r7_young", fwd_data, 32'd2);
    check_eq("fwd_r7_hit", fwd_hit, 1);
    idle(3);
    check_eq("rf_r7", rf[7], 32'd2);
    check_eq("rf_r3", rf[3], 32'hA);
    check_eq("rf_r4", rf[4], 32'hB);
    check_eq("rf_r0", rf[0], 32'd0);
    check_order();

    // 10 back-to-back writes, then a 20-cycle mixed-source stream
    for (int i = 0; i < 10; i++)
      step(1'b1, AW'(8 + i), DW'(32'h100 + i), 1'b0, '0, '0, AW'(8 + i));
    idle(3);
    for (int i = 0; i < 20; i++)
      step(i % 2 == 0, AW'(1 + i % 6), DW'($urandom), i % 2 == 1, AW'(1 + i % 5), DW'($urandom),
           AW'($urandom_range(0, 7)));
    idle(3);
    check_order();

    // reset mid-stream
    for (int i = 0; i < 5; i++)
      step(1'b1, AW'(20 + i), DW'(32'hC0DE_0000 + i), 1'b0, '0, '0, AW'(20 + i));
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    fwd_reg   = 5'd24;
    rst       = 1'b0;
    #1;
    check_eq("mid_rst_count", count, 0);
    check_eq("mid_rst_regWrite", regWrite, 0);
    check_eq("mid_rst_writeReg", writeReg, 0);
    check_eq("mid_rst_writeData", writeData, 0);
    check_eq("mid_rst_fwd_hit", fwd_hit, 0);
    repeat (mq.size() + (m_ow ? 1 : 0)) void'(accepted.pop_back());
    mq.delete();
    m_ow = 1'b0;
    m_wr = '0;
    m_wd = '0;
    check_order();
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    idle(3);
    check_order();

    // randomized traffic; a stalled memory request keeps its fields
    mpend = 1'b0;
    mv = 1'b0; mr = '0; md = '0;
    for (int i = 0; i < 400; i++) begin
      if (!mpend) begin
        mv = 1'($urandom_range(0, 1));
        mr = AW'($urandom_range(0, 7));
        md = $urandom;
      end
      step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom, mv, mr, md,
           AW'($urandom_range(0, 7)));
      mpend = mv && !last_m_acc;
    end
    idle(4);
    check_order();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
